// File: rtl/pwm_capture_if.sv
// Result channel of pwm_capture: per-colour duty counts with a valid/ready
// handshake and a sticky overrun flag. The capture block drives the master side.
interface pwm_capture_if #(
    parameter int CNT_W = 8
);
    logic [CNT_W-1:0] duty_r;
    logic [CNT_W-1:0] duty_g;
    logic [CNT_W-1:0] duty_b;
    logic             out_valid;
    logic             out_ready;
    logic             overrun;

    modport master (
        output duty_r, duty_g, duty_b, out_valid, overrun,
        input  out_ready
    );

    modport slave (
        input  duty_r, duty_g, duty_b, out_valid, overrun,
        output out_ready
    );
endinterface

// File: rtl/pwm_capture.sv
// Measures the high time of three frame-aligned RGB PWM inputs over one 2^CNT_W window.
// Define PWM_CAPTURE_SYNC_EN to put a 2-flop synchronizer in front of edge detection.
module pwm_capture #(
    parameter int CNT_W          = 8,
    parameter int TIMEOUT_CYCLES = 512
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pwm_r,
    input  logic          pwm_g,
    input  logic          pwm_b,
    pwm_capture_if.master res
);
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic {SEARCH, MEASURE} state_t;

    state_t           state;
    logic [2:0]       smp;
    logic [2:0]       prev;
    logic [CNT_W-1:0] win;
    logic [CNT_W:0]   cnt_r, cnt_g, cnt_b;
    logic [CNT_W:0]   sum_r, sum_g, sum_b;
    logic [TO_W-1:0]  timeout;
    logic             rise, win_last, to_hit, publish;
    logic [CNT_W-1:0] pub_r, pub_g, pub_b;

`ifdef PWM_CAPTURE_SYNC_EN
    logic [2:0] sync1, sync2;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {pwm_r, pwm_g, pwm_b};
            sync2 <= sync1;
        end
    end

    assign smp = sync2;
`else
    assign smp = {pwm_r, pwm_g, pwm_b};
`endif

    // Counters are one bit wider than the window so a full-high channel can reach 2^CNT_W.
    function automatic logic [CNT_W-1:0] sat(input logic [CNT_W:0] v);
        return v[CNT_W] ? '1 : v[CNT_W-1:0];
    endfunction

    always_comb begin
        rise     = |(smp & ~prev);
        sum_r    = cnt_r + {{CNT_W{1'b0}}, smp[2]};
        sum_g    = cnt_g + {{CNT_W{1'b0}}, smp[1]};
        sum_b    = cnt_b + {{CNT_W{1'b0}}, smp[0]};
        win_last = (state == MEASURE) && (win == '1);
        to_hit   = (state == SEARCH) && !rise && (timeout == TO_W'(TIMEOUT_CYCLES - 1));
        publish  = win_last || to_hit;
        pub_r    = win_last ? sat(sum_r) : {CNT_W{smp[2]}};
        pub_g    = win_last ? sat(sum_g) : {CNT_W{smp[1]}};
        pub_b    = win_last ? sat(sum_b) : {CNT_W{smp[0]}};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= SEARCH;
            prev          <= '0;
            win           <= '0;
            cnt_r         <= '0;
            cnt_g         <= '0;
            cnt_b         <= '0;
            timeout       <= '0;
            res.duty_r    <= '0;
            res.duty_g    <= '0;
            res.duty_b    <= '0;
            res.out_valid <= 1'b0;
            res.overrun   <= 1'b0;
        end else begin
            prev <= smp;
            case (state)
                SEARCH: begin
                    if (rise) begin
                        state   <= MEASURE;
                        win     <= CNT_W'(1);
                        cnt_r   <= {{CNT_W{1'b0}}, smp[2]};
                        cnt_g   <= {{CNT_W{1'b0}}, smp[1]};
                        cnt_b   <= {{CNT_W{1'b0}}, smp[0]};
                        timeout <= '0;
                    end else if (to_hit) begin
                        timeout <= '0;
                    end else begin
                        timeout <= timeout + 1'b1;
                    end
                end
                MEASURE: begin
                    cnt_r <= sum_r;
                    cnt_g <= sum_g;
                    cnt_b <= sum_b;
                    win   <= win + 1'b1;
                    if (win_last) begin
                        state   <= SEARCH;
                        timeout <= '0;
                    end
                end
                default: state <= SEARCH;
            endcase

            // A fresh result wins over a same-cycle acceptance of the old one.
            if (publish) begin
                res.duty_r    <= pub_r;
                res.duty_g    <= pub_g;
                res.duty_b    <= pub_b;
                res.out_valid <= 1'b1;
                if (res.out_valid && !res.out_ready) begin
                    res.overrun <= 1'b1;
                end
            end else if (res.out_valid && res.out_ready) begin
                res.out_valid <= 1'b0;
            end
        end
    end
endmodule
